// File: rtl/seq6_pkg.sv
// Shared constants, controller state type and next-code helper for the
// modulo-6 sequence counter and its run controller.
package seq6_pkg;

  localparam logic [2:0] SEQ_S0 = 3'b010;
  localparam logic [2:0] SEQ_S1 = 3'b011;
  localparam logic [2:0] SEQ_S2 = 3'b111;
  localparam logic [2:0] SEQ_S3 = 3'b110;
  localparam logic [2:0] SEQ_S4 = 3'b100;
  localparam logic [2:0] SEQ_S5 = 3'b000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } run_state_e;

  // Illegal codes (001, 101) fall back to the sequence start.
  function automatic logic [2:0] seq6_next(input logic [2:0] cur);
    logic [2:0] nxt;
    case (cur)
      SEQ_S0:  nxt = SEQ_S1;
      SEQ_S1:  nxt = SEQ_S2;
      SEQ_S2:  nxt = SEQ_S3;
      SEQ_S3:  nxt = SEQ_S4;
      SEQ_S4:  nxt = SEQ_S5;
      SEQ_S5:  nxt = SEQ_S0;
      default: nxt = SEQ_S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/seq6_core.sv
// Modulo-6 sequence counter with step enable, synchronous clear and a
// registered wrap pulse on the 000 -> 010 step.
module seq6_core
  import seq6_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] q,
  output logic       wrap
);

  logic [2:0] r_q;
  logic       r_wrap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= SEQ_S0;
      r_wrap <= 1'b0;
    end else if (clr) begin
      r_q    <= SEQ_S0;
      r_wrap <= 1'b0;
    end else if (en) begin
      r_q    <= seq6_next(r_q);
      r_wrap <= (r_q == SEQ_S5);
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;

endmodule

// File: rtl/seq6_run_ctrl.sv
// Runs the modulo-6 sequence counter for N full sequences with hold/abort,
// reporting busy, remaining count and a completion pulse.
//
// state | meaning
// IDLE  | waiting for start; q parked at 010
// RUN   | stepping one code per cycle
// PAUSE | hold seen; q and remaining frozen
module seq6_run_ctrl
  import seq6_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cycles,
  input  logic             hold,
  input  logic             abort,
  output logic [2:0]       q,
  output logic             wrap,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] remaining
);

  run_state_e       r_state;
  run_state_e       w_state_nxt;
  logic [LEN_W-1:0] r_remaining;
  logic [LEN_W-1:0] w_remaining_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_busy;
  logic             w_en;
  logic             w_clr;
  logic [2:0]       w_q;

  seq6_core u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_en),
    .clr   (w_clr),
    .q     (w_q),
    .wrap  (wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_done_nxt      = 1'b0;
    w_en            = 1'b0;
    w_clr           = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (cycles != '0) begin
            w_state_nxt     = RUN;
            w_remaining_nxt = cycles;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      RUN, PAUSE: begin
        if (abort) begin
          w_clr           = 1'b1;
          w_state_nxt     = IDLE;
          w_remaining_nxt = '0;
        end else if (hold) begin
          w_state_nxt = PAUSE;
        end else begin
          w_en        = 1'b1;
          w_state_nxt = RUN;
          // The 000 -> 010 step closes one sequence; the last one ends the run.
          if (w_q == SEQ_S5) begin
            if (r_remaining <= LEN_W'(1)) begin
              w_remaining_nxt = '0;
              w_done_nxt      = 1'b1;
              w_state_nxt     = IDLE;
            end else begin
              w_remaining_nxt = r_remaining - LEN_W'(1);
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign q         = w_q;
  assign busy      = r_busy;
  assign done      = r_done;
  assign remaining = r_remaining;

endmodule

// File: tb/tb_seq6_run_ctrl.sv
// Directed, table-driven bench for seq6_run_ctrl: each record gives the inputs
// applied before an edge and the outputs expected just after that edge.
module tb_seq6_run_ctrl;

  localparam int LEN_W = 8;
  localparam logic [2:0] C0 = 3'b010;
  localparam logic [2:0] C1 = 3'b011;
  localparam logic [2:0] C2 = 3'b111;
  localparam logic [2:0] C3 = 3'b110;
  localparam logic [2:0] C4 = 3'b100;
  localparam logic [2:0] C5 = 3'b000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] cycles = '0;
  logic             hold = 1'b0;
  logic             abort = 1'b0;
  logic [2:0]       q;
  logic             wrap;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] remaining;

  int n_cmp = 0;
  int n_bad = 0;

  seq6_run_ctrl #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cycles    (cycles),
    .hold      (hold),
    .abort     (abort),
    .q         (q),
    .wrap      (wrap),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rn;
    logic             st;
    logic [LEN_W-1:0] cyc;
    logic             hd;
    logic             ab;
    logic [2:0]       eq;
    logic             ew;
    logic             eb;
    logic             ed;
    logic [LEN_W-1:0] er;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rn, input logic st, input logic [LEN_W-1:0] cyc,
                              input logic hd, input logic ab, input logic [2:0] eq,
                              input logic ew, input logic eb, input logic ed,
                              input logic [LEN_W-1:0] er);
    vec_t v;
    v.rn = rn; v.st = st; v.cyc = cyc; v.hd = hd; v.ab = ab;
    v.eq = eq; v.ew = ew; v.eb = eb; v.ed = ed; v.er = er;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    rst_n  = v.rn;
    start  = v.st;
    cycles = v.cyc;
    hold   = v.hd;
    abort  = v.ab;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({q, wrap, busy, done, remaining} !== {v.eq, v.ew, v.eb, v.ed, v.er}) begin
      n_bad++;
      $display("FAIL %s: got q=%b wrap=%b busy=%b done=%b rem=%0d, want q=%b wrap=%b busy=%b done=%b rem=%0d",
               tag, q, wrap, busy, done, remaining, v.eq, v.ew, v.eb, v.ed, v.er);
    end
  endtask

  initial begin
    logic [2:0] code [6];
    code[0] = C1; code[1] = C2; code[2] = C3; code[3] = C4; code[4] = C5; code[5] = C0;

    // Reset held two edges with start asserted.
    tbl.push_back(mk(0, 1, 5, 0, 0, C0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5, 0, 0, C0, 0, 0, 0, 0));
    // Normal run of two sequences.
    tbl.push_back(mk(1, 1, 2, 0, 0, C0, 0, 1, 0, 2));
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 6; i++) begin
        logic last;
        last = (i == 5);
        tbl.push_back(mk(1, 0, 0, 0, 0, code[i], last, !(last && s == 1), last && s == 1,
                         last ? LEN_W'(1 - s) : LEN_W'(2 - s)));
      end
    end
    tbl.push_back(mk(1, 0, 0, 0, 0, C0, 0, 0, 0, 0));
    // Zero-length start.
    tbl.push_back(mk(1, 1, 0, 0, 0, C0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, C0, 0, 0, 0, 0));
    // Abort while idle is ignored.
    tbl.push_back(mk(1, 0, 0, 0, 1, C0, 0, 0, 0, 0));
    // Single run with a start mid-run and a start on the final wrap edge, both ignored.
    tbl.push_back(mk(1, 1, 1, 0, 0, C0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, C1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 7, 0, 0, C2, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, C3, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, C4, 0, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, C5, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 4, 0, 0, C0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, C0, 0, 0, 0, 0));

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Hold for three cycles at q=111: done moves from k+6 to k+9.
    apply(mk(1, 1, 1, 0, 0, C0, 0, 1, 0, 1), "hold_start");
    apply(mk(1, 0, 0, 0, 0, C1, 0, 1, 0, 1), "hold_k1");
    apply(mk(1, 0, 0, 0, 0, C2, 0, 1, 0, 1), "hold_k2");
    apply(mk(1, 0, 0, 1, 0, C2, 0, 1, 0, 1), "hold_k3");
    apply(mk(1, 0, 0, 1, 0, C2, 0, 1, 0, 1), "hold_k4");
    apply(mk(1, 0, 0, 1, 0, C2, 0, 1, 0, 1), "hold_k5");
    apply(mk(1, 0, 0, 0, 0, C3, 0, 1, 0, 1), "hold_k6");
    apply(mk(1, 0, 0, 0, 0, C4, 0, 1, 0, 1), "hold_k7");
    apply(mk(1, 0, 0, 0, 0, C5, 0, 1, 0, 1), "hold_k8");
    apply(mk(1, 0, 0, 0, 0, C0, 1, 0, 1, 0), "hold_done_k9");

    // Abort together with hold at q=110 in the second sequence of three.
    apply(mk(1, 1, 3, 0, 0, C0, 0, 1, 0, 3), "abort_start");
    for (int i = 0; i < 6; i++)
      apply(mk(1, 0, 0, 0, 0, code[i], i == 5, 1, 0, (i == 5) ? LEN_W'(2) : LEN_W'(3)),
            $sformatf("abort_seq1_%0d", i));
    apply(mk(1, 0, 0, 0, 0, C1, 0, 1, 0, 2), "abort_s2_011");
    apply(mk(1, 0, 0, 0, 0, C2, 0, 1, 0, 2), "abort_s2_111");
    apply(mk(1, 0, 0, 0, 0, C3, 0, 1, 0, 2), "abort_s2_110");
    apply(mk(1, 0, 0, 1, 1, C0, 0, 0, 0, 0), "abort_hit");
    apply(mk(1, 0, 0, 0, 0, C0, 0, 0, 0, 0), "abort_after");

    // Reset mid-run at q=100, then a one-sequence run completes at start+6.
    apply(mk(1, 1, 2, 0, 0, C0, 0, 1, 0, 2), "rst_start");
    for (int i = 0; i < 4; i++)
      apply(mk(1, 0, 0, 0, 0, code[i], 0, 1, 0, 2), $sformatf("rst_step%0d", i));
    apply(mk(0, 0, 0, 0, 0, C0, 0, 0, 0, 0), "rst_mid");
    apply(mk(1, 1, 1, 0, 0, C0, 0, 1, 0, 1), "rst_restart");
    for (int i = 0; i < 6; i++)
      apply(mk(1, 0, 0, 0, 0, code[i], i == 5, i != 5, i == 5, (i == 5) ? LEN_W'(0) : LEN_W'(1)),
            $sformatf("rst_run%0d", i));

    // Abort coincident with the final 000 -> 010 step.
    apply(mk(1, 1, 1, 0, 0, C0, 0, 1, 0, 1), "race_start");
    for (int i = 0; i < 5; i++)
      apply(mk(1, 0, 0, 0, 0, code[i], 0, 1, 0, 1), $sformatf("race_step%0d", i));
    apply(mk(1, 0, 0, 0, 1, C0, 0, 0, 0, 0), "race_abort");
    apply(mk(1, 0, 0, 0, 0, C0, 0, 0, 0, 0), "race_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq6_run_ctrl.md
# seq6_run_ctrl

Run controller for the team's modulo-6 sequence counter (code order 010→011→111→110→100→000→010). It accepts a start request carrying a count of full sequences N and steps the counter through exactly N sequences. Stepping can be held or aborted at any point, and the block reports progress and completion. It sits between the control logic that issues start, hold and abort and any logic that consumes the 3-bit sequence code and its wrap pulse.

## Interface
- LEN_W, default 8: width of the sequence-count request and the remaining-count output.

- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request; accepted only when idle.
- cycles  in  LEN_W  number of full 6-step sequences to run; sampled on an accepted start.
- hold  in  1  level; while high and running, the sequence freezes.
- abort  in  1  single-cycle request; cancels a run in progress.
- q  out  3  current sequence code.
- wrap  out  1  one-cycle pulse when q re-enters 010 from 000.
- busy  out  1  high while a run is in progress (running or held).
- done  out  1  one-cycle pulse when a run completes normally.
- remaining  out  LEN_W  sequences not yet completed.

## Operation
- Controller states: IDLE, RUN, PAUSE.
- IDLE:
  - start with cycles≠0 → RUN; remaining←cycles; q holds 010.
  - start with cycles=0 → stay IDLE; done=1 for one cycle; q unchanged.
- RUN:
  - Each cycle with hold=0 advances q one step.
  - hold=1 → PAUSE with no step taken that edge.
  - The step 000→010 sets wrap=1 and decrements remaining.
  - If that decrement reaches 0, the same edge sets done=1, clears busy and returns to IDLE.
- PAUSE:
  - q and remaining are frozen.
  - hold=0 → RUN; stepping resumes on the following edge.
- abort in RUN or PAUSE:
  - Returns to IDLE; q←010; remaining←0; wrap=0; done=0.
  - abort beats hold and beats a coincident final wrap. The run is then treated as aborted: no done, no wrap.
- Ignored inputs:
  - start while busy, including the cycle in which the final wrap occurs.
  - abort in IDLE.
- Illegal q codes (001, 101) go to 010 on the next step. They are unreachable after reset.
- remaining is an unsigned LEN_W-bit value and never underflows.

## Timing
- Reset values: q=010, wrap=0, busy=0, done=0, remaining=0, state IDLE.
- Reset applies on any edge with rst_n=0, including mid-run. No done is issued on reset.
- With start accepted at edge k (cycles=N, no hold):
  - busy=1 from edge k.
  - First step (q=011) at edge k+1.
  - wrap pulses at edges k+6, k+12, …, k+6N.
  - done and busy falling both occur at edge k+6N.
- Each cycle spent with hold=1 during a run delays all later events by one cycle.
- Hold timing: hold seen at edge j means no step at edge j. Hold released (hold=0) at edge m means the next step is at edge m+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package seq6_pkg holds:
  - The six q code constants, named SEQ_S0..SEQ_S5.
  - The controller state enum: IDLE, RUN, PAUSE.
- Sub-module seq6_core is the counter with step enable and synchronous clear.
  - Ports: clk, rst_n, en, clr, q[2:0], wrap.
  - It implements code order, wrap generation and recovery from illegal codes.
- seq6_run_ctrl instantiates one seq6_core and adds:
  - the FSM;
  - the remaining counter;
  - done and busy generation.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with start=1 → q=010, busy=0, done=0, wrap=0, remaining=0.
- Normal run: start with cycles=2 → q steps 011,111,110,100,000,010 twice. wrap at k+6 and k+12. remaining 2→1→0. done and busy falling at k+12.
- Zero length: start with cycles=0 → done=1 at edge k only, busy never rises, q stays 010.
- Hold:
  - Run with cycles=1; raise hold when q=111 for 3 cycles → q stays 111 for 3 extra cycles; done arrives at k+9.
  - start pulsed mid-run → ignored; remaining unchanged.
- Abort: run with cycles=3; assert abort and hold together when q=110 in sequence 2 → next edge gives q=010, busy=0, remaining=0, no done, no wrap.
- Mid-run reset and abort-vs-wrap race:
  - rst_n=0 for one cycle at q=100 → reset values restored; a following start with cycles=1 completes at start edge+6.
  - abort coincident with the final 000→010 step → no done.
